// File: rtl/fetch_ctrl_if.sv
// Loader stream and instruction-cache write port bundle for fetch_ctrl.
// The controller connects through the slave modport; the loader/cache side uses master.
interface fetch_ctrl_if #(
    parameter int XLEN = 64
);
    logic            load_valid;
    logic            load_ready;
    logic [31:0]     load_data;
    logic            load_last;
    logic            wr_instr_en;
    logic [31:0]     wr_instr;
    logic [XLEN-1:0] wr_addr;

    modport master (
        output load_valid, load_data, load_last,
        input  load_ready, wr_instr_en, wr_instr, wr_addr
    );

    modport slave (
        input  load_valid, load_data, load_last,
        output load_ready, wr_instr_en, wr_instr, wr_addr
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boots the instruction cache from a streaming loader, then drives PC/fetch/flush.
// Optional performance counters are enabled by defining FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
    parameter int XLEN         = 64,
    parameter int LOAD_DEPTH   = 1024,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_start_i,
    input  logic            run_i,
    input  logic            halt_i,
    fetch_ctrl_if.slave     ld,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_pc_i,
    output logic            pc_en_o,
    output logic            pc_src_o,
    output logic [XLEN-1:0] branch_pc_o,
    output logic            if_en_o,
    output logic            flush_o,
    output logic            loaded_o,
    output logic [2:0]      state_o
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_stall_o,
    output logic [31:0]     perf_flush_o
`endif
);

    localparam int CW = $clog2(LOAD_DEPTH);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_IDX   = CW'(LOAD_DEPTH - 1);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            loaded_q, loaded_d;
    logic [XLEN-1:0] branch_pc_q, branch_pc_d;

    logic            load_ready, wr_en;
    logic [31:0]     wr_data;
    logic [XLEN-1:0] wr_addr, branch_pc_out;
    logic            pc_en, pc_src, if_en, flush;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d       = state_q;
        count_d       = count_q;
        flush_cnt_d   = flush_cnt_q;
        loaded_d      = loaded_q;
        branch_pc_d   = branch_pc_q;
        branch_pc_out = branch_pc_q;
        load_ready    = 1'b0;
        wr_en         = 1'b0;
        wr_data       = '0;
        wr_addr       = '0;
        pc_en         = 1'b0;
        pc_src        = 1'b0;
        if_en         = 1'b0;
        flush         = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (load_start_i) begin
                    state_d = S_LOAD;
                    count_d = '0;
                end else if (run_i && loaded_q) begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                if (ld.load_valid) begin
                    wr_en   = 1'b1;
                    wr_data = ld.load_data;
                    wr_addr = XLEN'({count_q, 2'b00});
                    count_d = count_q + CW'(1);
                    // The image ends on the flagged word or when the cache window is full.
                    if (ld.load_last || count_q == LAST_IDX) begin
                        state_d  = S_IDLE;
                        loaded_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (halt_i) begin
                    state_d = S_HALT;
                end else if (branch_taken_i) begin
                    pc_en         = 1'b1;
                    pc_src        = 1'b1;
                    flush         = 1'b1;
                    branch_pc_d   = branch_pc_i;
                    branch_pc_out = branch_pc_i;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end
                end else if (!stall_i) begin
                    pc_en = 1'b1;
                    if_en = 1'b1;
                end
            end
            S_FLUSH: begin
                // Branches seen here come from the wrong path and are dropped.
                flush       = 1'b1;
                pc_en       = !stall_i;
                flush_cnt_d = flush_cnt_q - FW'(1);
                if (halt_i) begin
                    state_d = S_HALT;
                end else if (flush_cnt_q == FW'(1)) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst_i) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            flush_cnt_q <= '0;
            loaded_q    <= 1'b0;
            branch_pc_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            flush_cnt_q <= flush_cnt_d;
            loaded_q    <= loaded_d;
            branch_pc_q <= branch_pc_d;
        end
    end

    assign ld.load_ready  = load_ready;
    assign ld.wr_instr_en = wr_en;
    assign ld.wr_instr    = wr_data;
    assign ld.wr_addr     = wr_addr;
    assign pc_en_o        = pc_en;
    assign pc_src_o       = pc_src;
    assign branch_pc_o    = branch_pc_out;
    assign if_en_o        = if_en;
    assign flush_o        = flush;
    assign loaded_o       = loaded_q;
    assign state_o        = state_q;

`ifdef FETCH_CTRL_PERF_EN
    logic        stall_evt, branch_evt;
    logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

    assign stall_evt  = (state_q == S_RUN) && stall_i && !branch_taken_i && !halt_i;
    assign branch_evt = (state_q == S_RUN) && branch_taken_i && !halt_i;

    // Both counters saturate rather than wrap.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_evt && perf_stall_q != '1)  perf_stall_d = perf_stall_q + 32'd1;
        if (branch_evt && perf_flush_q != '1) perf_flush_d = perf_flush_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_o = perf_stall_q;
    assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run against a behavioural model.
// Define FETCH_CTRL_PERF_EN to also exercise the performance counters.
module tb_fetch_ctrl;

    localparam int XLEN  = 64;
    localparam int DEPTH = 8;
    localparam int FLUSH = 2;

    localparam int ST_IDLE  = 0;
    localparam int ST_LOAD  = 1;
    localparam int ST_RUN   = 2;
    localparam int ST_FLUSH = 3;
    localparam int ST_HALT  = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            load_start_i, run_i, halt_i, stall_i, branch_taken_i;
    logic [XLEN-1:0] branch_pc_i;
    logic            pc_en_o, pc_src_o, if_en_o, flush_o, loaded_o;
    logic [XLEN-1:0] branch_pc_o;
    logic [2:0]      state_o;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0]     perf_stall_o, perf_flush_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    fetch_ctrl_if #(.XLEN(XLEN)) ld_if ();

    fetch_ctrl #(.XLEN(XLEN), .LOAD_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .load_start_i   (load_start_i),
        .run_i          (run_i),
        .halt_i         (halt_i),
        .ld             (ld_if),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_pc_i    (branch_pc_i),
        .pc_en_o        (pc_en_o),
        .pc_src_o       (pc_src_o),
        .branch_pc_o    (branch_pc_o),
        .if_en_o        (if_en_o),
        .flush_o        (flush_o),
        .loaded_o       (loaded_o),
        .state_o        (state_o)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_stall_o   (perf_stall_o),
        .perf_flush_o   (perf_flush_o)
`endif
    );

    typedef struct packed {
        logic [2:0]      state;
        logic            loaded, ready, wr_en;
        logic [31:0]     wr_data;
        logic [XLEN-1:0] wr_addr;
        logic            pc_en, pc_src, if_en, flush;
        logic [XLEN-1:0] bpc;
    } obs_t;

    // Reference model: mode, words taken in this load, flush cycles left, sticky flags.
    int              m_state, m_words, m_flush_left, m_perf_stall, m_perf_flush;
    logic            m_loaded;
    logic [XLEN-1:0] m_bpc;

    // Advance to just after the next rising edge; inputs driven here apply to the following cycle.
    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        load_start_i = 0; run_i = 0; halt_i = 0; stall_i = 0; branch_taken_i = 0;
        branch_pc_i = '0;
        ld_if.load_valid = 0; ld_if.load_data = '0; ld_if.load_last = 0;
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_words = 0; m_flush_left = 0;
        m_perf_stall = 0; m_perf_flush = 0; m_loaded = 0; m_bpc = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1;
        adv();
        adv();
        rst_i = 0;
        model_reset();
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.state = state_o; o.loaded = loaded_o; o.ready = ld_if.load_ready;
        o.wr_en = ld_if.wr_instr_en; o.wr_data = ld_if.wr_instr; o.wr_addr = ld_if.wr_addr;
        o.pc_en = pc_en_o; o.pc_src = pc_src_o; o.if_en = if_en_o; o.flush = flush_o;
        o.bpc = branch_pc_o;
        return o;
    endfunction

    // Expected outputs for the current cycle from current inputs; then advances the model across the edge.
    task automatic model_step(output obs_t e, output bit ctrl_dc);
        e = '0;
        ctrl_dc = 0;
        e.state = 3'(m_state); e.loaded = m_loaded; e.bpc = m_bpc;
        case (m_state)
            ST_IDLE, ST_HALT: begin
                if (load_start_i) begin m_state = ST_LOAD; m_words = 0; end
                else if (run_i && m_loaded) m_state = ST_RUN;
            end
            ST_LOAD: begin
                e.ready = 1;
                if (ld_if.load_valid) begin
                    e.wr_en = 1; e.wr_data = ld_if.load_data; e.wr_addr = XLEN'(m_words * 4);
                    m_words++;
                    if (ld_if.load_last || m_words == DEPTH) begin m_state = ST_IDLE; m_loaded = 1; end
                end
            end
            ST_RUN: begin
                if (halt_i) m_state = ST_HALT;
                else if (branch_taken_i) begin
                    e.pc_en = 1; e.pc_src = 1; e.flush = 1; e.bpc = branch_pc_i;
                    m_bpc = branch_pc_i; m_perf_flush++;
                    if (FLUSH > 1) begin m_state = ST_FLUSH; m_flush_left = FLUSH - 1; end
                end else if (stall_i) m_perf_stall++;
                else begin e.pc_en = 1; e.if_en = 1; end
            end
            default: begin
                e.flush = 1; e.pc_en = !stall_i;
                if (halt_i) begin m_state = ST_HALT; ctrl_dc = 1; end
                else begin
                    m_flush_left--;
                    if (m_flush_left == 0) m_state = ST_RUN;
                end
            end
        endcase
    endtask

    task automatic enter_run();
        load_start_i = 1; adv(); load_start_i = 0;
        ld_if.load_valid = 1; ld_if.load_data = 32'h0000_0013; ld_if.load_last = 1; adv();
        ld_if.load_valid = 0; ld_if.load_last = 0;
        run_i = 1; adv(); run_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
        checks++; if ({loaded_o, pc_en_o, pc_src_o, if_en_o, flush_o, ld_if.load_ready, ld_if.wr_instr_en} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0", {loaded_o, pc_en_o, pc_src_o, if_en_o, flush_o, ld_if.load_ready, ld_if.wr_instr_en});
        end
        checks++; if (branch_pc_o !== '0) begin errors++; $display("FAIL reset_bpc got %h exp 0", branch_pc_o); end
    endtask

    task automatic test_load_three();
        do_reset();
        load_start_i = 1; adv(); load_start_i = 0;
        for (int i = 0; i < 3; i++) begin
            ld_if.load_valid = 1; ld_if.load_data = 32'hA000_0000 + 32'(i); ld_if.load_last = (i == 2);
            #1;
            checks++; if ({ld_if.wr_instr_en, ld_if.wr_addr, ld_if.wr_instr} !== {1'b1, XLEN'(i * 4), 32'hA000_0000 + 32'(i)}) begin
                errors++; $display("FAIL load3_word%0d got en=%b addr=%h data=%h exp addr=%0h", i, ld_if.wr_instr_en, ld_if.wr_addr, ld_if.wr_instr, i * 4);
            end
            adv();
        end
        ld_if.load_valid = 0; ld_if.load_last = 0;
        #1;
        checks++; if ({state_o, loaded_o} !== {3'd0, 1'b1}) begin errors++; $display("FAIL load3_done got state=%0d loaded=%b exp 0/1", state_o, loaded_o); end
    endtask

    task automatic test_load_gaps();
        bit pat [6] = '{1, 0, 1, 0, 0, 1};
        int w = 0;
        do_reset();
        load_start_i = 1; adv(); load_start_i = 0;
        for (int i = 0; i < 6; i++) begin
            ld_if.load_valid = pat[i]; ld_if.load_data = 32'h5500 + 32'(i); ld_if.load_last = pat[i] && (w == 2);
            #1;
            checks++; if (ld_if.wr_instr_en !== pat[i] || (pat[i] && ld_if.wr_addr !== XLEN'(w * 4))) begin
                errors++; $display("FAIL gap_cyc%0d got en=%b addr=%h exp en=%b addr=%0h", i, ld_if.wr_instr_en, ld_if.wr_addr, pat[i], w * 4);
            end
            if (pat[i]) w++;
            adv();
        end
        clear_inputs();
        #1;
        checks++; if ({state_o, loaded_o} !== {3'd0, 1'b1}) begin errors++; $display("FAIL gap_done got state=%0d loaded=%b exp 0/1", state_o, loaded_o); end
    endtask

    task automatic test_run_gate();
        do_reset();
        run_i = 1; adv(); run_i = 0;
        #1;
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL run_unloaded got state=%0d exp 0", state_o); end
        enter_run();
        #1;
        checks++; if ({state_o, pc_en_o, if_en_o, pc_src_o, flush_o} !== {3'd2, 4'b1100}) begin
            errors++; $display("FAIL run_loaded got state=%0d pc_en=%b if_en=%b exp 2/1/1", state_o, pc_en_o, if_en_o);
        end
    endtask

    task automatic test_branch();
        do_reset();
        enter_run();
        branch_taken_i = 1; branch_pc_i = 64'h100;
        #1;
        checks++; if ({pc_en_o, pc_src_o, flush_o, if_en_o, branch_pc_o} !== {4'b1110, 64'h100}) begin
            errors++; $display("FAIL branch_take got pc_en=%b src=%b flush=%b if_en=%b bpc=%h exp 1/1/1/0 100", pc_en_o, pc_src_o, flush_o, if_en_o, branch_pc_o);
        end
        adv();
        branch_pc_i = 64'hdead_0000;
        #1;
        checks++; if ({state_o, flush_o, if_en_o, pc_src_o, branch_pc_o} !== {3'd3, 3'b100, 64'h100}) begin
            errors++; $display("FAIL branch_flush2 got state=%0d flush=%b if_en=%b src=%b bpc=%h exp 3/1/0/0 100", state_o, flush_o, if_en_o, pc_src_o, branch_pc_o);
        end
        adv();
        branch_taken_i = 0;
        #1;
        checks++; if ({state_o, flush_o, pc_en_o, pc_src_o, branch_pc_o} !== {3'd2, 3'b010, 64'h100}) begin
            errors++; $display("FAIL branch_done got state=%0d flush=%b pc_en=%b src=%b bpc=%h exp 2/0/1/0 100", state_o, flush_o, pc_en_o, pc_src_o, branch_pc_o);
        end
    endtask

    task automatic test_priority();
        do_reset();
        enter_run();
        stall_i = 1; branch_taken_i = 1; branch_pc_i = 64'h200;
        #1;
        checks++; if ({pc_en_o, pc_src_o, flush_o} !== 3'b111) begin errors++; $display("FAIL stall_branch got %b exp 111", {pc_en_o, pc_src_o, flush_o}); end
        adv();
        branch_taken_i = 0;
        #1;
        checks++; if ({pc_en_o, flush_o} !== 2'b01) begin errors++; $display("FAIL flush_stall got pc_en=%b flush=%b exp 0/1", pc_en_o, flush_o); end
        adv();
        #1;
        checks++; if ({state_o, pc_en_o, if_en_o, flush_o} !== {3'd2, 3'b000}) begin
            errors++; $display("FAIL stall_only got state=%0d pc_en=%b if_en=%b flush=%b exp 2/0/0/0", state_o, pc_en_o, if_en_o, flush_o);
        end
        adv();
        stall_i = 0; halt_i = 1; branch_taken_i = 1; branch_pc_i = 64'h300;
        #1;
        checks++; if ({pc_en_o, pc_src_o, flush_o, if_en_o, branch_pc_o} !== {4'b0000, 64'h200}) begin
            errors++; $display("FAIL halt_branch got pc_en=%b flush=%b bpc=%h exp 0/0 200", pc_en_o, flush_o, branch_pc_o);
        end
        adv();
        halt_i = 0; branch_taken_i = 0;
        #1;
        checks++; if ({state_o, branch_pc_o} !== {3'd4, 64'h200}) begin errors++; $display("FAIL halt_state got state=%0d bpc=%h exp 4 200", state_o, branch_pc_o); end
        run_i = 1; adv(); run_i = 0;
        #1;
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL halt_resume got state=%0d exp 2", state_o); end
    endtask

    task automatic test_depth_limit();
        do_reset();
        load_start_i = 1; adv(); load_start_i = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_if.load_valid = 1; ld_if.load_data = 32'(i);
            if (i == DEPTH - 1) begin
                #1;
                checks++; if (ld_if.wr_addr !== XLEN'((DEPTH - 1) * 4)) begin
                    errors++; $display("FAIL depth_addr got %h exp %0h", ld_if.wr_addr, (DEPTH - 1) * 4);
                end
            end
            adv();
        end
        #1;
        checks++; if ({state_o, loaded_o, ld_if.load_ready, ld_if.wr_instr_en} !== {3'd0, 3'b100}) begin
            errors++; $display("FAIL depth_done got state=%0d loaded=%b ready=%b wr_en=%b exp 0/1/0/0", state_o, loaded_o, ld_if.load_ready, ld_if.wr_instr_en);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        load_start_i = 1; adv(); load_start_i = 0;
        ld_if.load_valid = 1; ld_if.load_last = 1; adv();
        ld_if.load_last = 0;
        load_start_i = 1; adv(); load_start_i = 0;
        adv();
        rst_i = 1; adv(); rst_i = 0;
        clear_inputs();
        #1;
        checks++; if ({state_o, loaded_o, ld_if.load_ready} !== {3'd0, 2'b00}) begin
            errors++; $display("FAIL reset_midload got state=%0d loaded=%b ready=%b exp 0/0/0", state_o, loaded_o, ld_if.load_ready);
        end
    endtask

    task automatic test_random();
        obs_t e, a;
        bit dc;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            adv();
            load_start_i     = ($urandom_range(0, 19) == 0);
            run_i            = ($urandom_range(0, 3) == 0);
            halt_i           = ($urandom_range(0, 24) == 0);
            stall_i          = ($urandom_range(0, 3) == 0);
            branch_taken_i   = ($urandom_range(0, 5) == 0);
            branch_pc_i      = {$urandom, $urandom};
            ld_if.load_valid = ($urandom_range(0, 2) != 0);
            ld_if.load_data  = $urandom;
            ld_if.load_last  = ($urandom_range(0, 5) == 0);
            #1;
            model_step(e, dc);
            a = observe();
            if (!e.wr_en) begin a.wr_data = '0; a.wr_addr = '0; end
            if (dc) begin {a.pc_en, a.pc_src, a.if_en, a.flush} = '0; {e.pc_en, e.pc_src, e.if_en, e.flush} = '0; end
            checks++; if (a !== e) begin errors++; $display("FAIL random_cyc%0d got %h exp %h", c, a, e); end
        end
        adv();
        clear_inputs();
`ifdef FETCH_CTRL_PERF_EN
        checks++; if ({perf_stall_o, perf_flush_o} !== {32'(m_perf_stall), 32'(m_perf_flush)}) begin
            errors++; $display("FAIL random_perf got %0d/%0d exp %0d/%0d", perf_stall_o, perf_flush_o, m_perf_stall, m_perf_flush);
        end
`endif
    endtask

`ifdef FETCH_CTRL_PERF_EN
    task automatic test_perf();
        do_reset();
        enter_run();
        stall_i = 1;
        repeat (5) adv();
        stall_i = 0;
        repeat (2) begin
            branch_taken_i = 1; branch_pc_i = 64'h40; adv();
            branch_taken_i = 0; adv();
        end
        adv();
        #1;
        checks++; if ({perf_stall_o, perf_flush_o} !== {32'd5, 32'd2}) begin
            errors++; $display("FAIL perf_count got %0d/%0d exp 5/2", perf_stall_o, perf_flush_o);
        end
        rst_i = 1; adv(); rst_i = 0;
        #1;
        checks++; if ({perf_stall_o, perf_flush_o} !== 64'd0) begin
            errors++; $display("FAIL perf_reset got %0d/%0d exp 0/0", perf_stall_o, perf_flush_o);
        end
    endtask
`endif

    initial begin
        clear_inputs();
        rst_i = 1;
        test_reset();
        test_load_three();
        test_load_gaps();
        test_run_gate();
        test_branch();
        test_priority();
        test_depth_limit();
        test_reset_mid_load();
        test_random();
`ifdef FETCH_CTRL_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
